// File: rtl/openofdm_rx_watchdog.sv
// Supervisory sequencer for the dot11 receive core: follows each reception through its phases
// and pulses a core reset with a recorded cause when a phase stalls or sees a bad header/length.
module openofdm_rx_watchdog #(
    parameter int unsigned TIMER_WIDTH   = 16,
    parameter int unsigned RST_PULSE_LEN = 4,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_sample_in_strobe,
    input  logic                   i_short_preamble_detected,
    input  logic                   i_long_preamble_detected,
    input  logic                   i_pkt_header_valid_strobe,
    input  logic                   i_pkt_header_valid,
    input  logic                   i_ht_unsupport,
    input  logic [15:0]            i_pkt_len,
    input  logic                   i_byte_out_strobe,
    input  logic                   i_fcs_out_strobe,
    input  logic [TIMER_WIDTH-1:0] i_long_timeout,
    input  logic [TIMER_WIDTH-1:0] i_sig_timeout,
    input  logic [TIMER_WIDTH-1:0] i_byte_timeout,
    input  logic [15:0]            i_max_pkt_len,
    output logic                   o_core_rst,
    output logic                   o_abort_strobe,
    output logic [2:0]             o_abort_code,
    output logic [CNT_WIDTH-1:0]   o_abort_count,
    output logic                   o_pkt_done_strobe,
    output logic [2:0]             o_state
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitLong  = 3'd1,
        StWaitSig   = 3'd2,
        StRxData    = 3'd3,
        StResetCore = 3'd4
    } state_e;

    localparam logic [2:0] CodeLong    = 3'd1;
    localparam logic [2:0] CodeSig     = 3'd2;
    localparam logic [2:0] CodeHeader  = 3'd3;
    localparam logic [2:0] CodeByte    = 3'd4;
    localparam logic [2:0] CodeLength  = 3'd5;
    localparam logic [2:0] CodeOverrun = 3'd6;

    localparam int unsigned PulseCntW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
    localparam logic [PulseCntW-1:0] PulseLast = PulseCntW'(RST_PULSE_LEN - 1);

    state_e                 r_state, w_state_d;
    logic [TIMER_WIDTH-1:0] r_timer, w_timer_d;
    logic [16:0]            r_byte_cnt, w_byte_cnt_d, w_byte_next;
    logic [15:0]            r_pkt_len, w_pkt_len_d;
    logic [PulseCntW-1:0]   r_pulse_cnt, w_pulse_cnt_d;
    logic                   r_core_rst;
    logic                   r_abort_strobe;
    logic [2:0]             r_abort_code;
    logic [CNT_WIDTH-1:0]   r_abort_count;
    logic                   r_pkt_done;
    logic                   w_abort;
    logic [2:0]             w_code;
    logic                   w_byte_clr;
    logic                   w_done_d;

    function automatic logic timed_out(input logic [TIMER_WIDTH-1:0] timer,
                                       input logic [TIMER_WIDTH-1:0] limit);
        return (limit != '0) && (timer >= limit);
    endfunction

    always_comb begin
        w_state_d     = r_state;
        w_abort       = 1'b0;
        w_code        = 3'd0;
        w_byte_clr    = 1'b0;
        w_byte_cnt_d  = r_byte_cnt;
        w_pkt_len_d   = r_pkt_len;
        w_pulse_cnt_d = r_pulse_cnt;
        w_done_d      = 1'b0;
        w_byte_next   = r_byte_cnt + 17'd1;

        // Strobes that advance the phase win over any abort check in the same cycle.
        unique case (r_state)
            StIdle: begin
                if (i_short_preamble_detected) w_state_d = StWaitLong;
            end
            StWaitLong: begin
                if (i_long_preamble_detected) begin
                    w_state_d = StWaitSig;
                end else if (timed_out(r_timer, i_long_timeout)) begin
                    w_abort = 1'b1;
                    w_code  = CodeLong;
                end
            end
            StWaitSig: begin
                if (i_pkt_header_valid_strobe) begin
                    if (!i_pkt_header_valid || i_ht_unsupport) begin
                        w_abort = 1'b1;
                        w_code  = CodeHeader;
                    end else if ((i_pkt_len == 16'd0) || (i_pkt_len > i_max_pkt_len)) begin
                        w_abort = 1'b1;
                        w_code  = CodeLength;
                    end else begin
                        w_state_d   = StRxData;
                        w_pkt_len_d = i_pkt_len;
                    end
                end else if (timed_out(r_timer, i_sig_timeout)) begin
                    w_abort = 1'b1;
                    w_code  = CodeSig;
                end
            end
            StRxData: begin
                if (i_fcs_out_strobe) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else if (i_byte_out_strobe && (w_byte_next > {1'b0, r_pkt_len})) begin
                    w_abort = 1'b1;
                    w_code  = CodeOverrun;
                end else if (timed_out(r_timer, i_byte_timeout)) begin
                    w_abort = 1'b1;
                    w_code  = CodeByte;
                end else if (i_byte_out_strobe) begin
                    w_byte_cnt_d = w_byte_next;
                    w_byte_clr   = 1'b1;
                end
            end
            StResetCore: begin
                if (r_pulse_cnt == '0) w_state_d = StIdle;
                else                   w_pulse_cnt_d = r_pulse_cnt - PulseCntW'(1);
            end
            default: w_state_d = StIdle;
        endcase

        if (w_abort) begin
            w_state_d     = StResetCore;
            w_pulse_cnt_d = PulseLast;
        end

        if (!i_enable) begin
            w_state_d = StIdle;
            w_abort   = 1'b0;
            w_done_d  = 1'b0;
        end

        if (w_state_d != StRxData) w_byte_cnt_d = '0;

        // Timer restarts on every phase entry and on each accepted data byte.
        if (!i_enable || (w_state_d != r_state) || w_byte_clr) begin
            w_timer_d = '0;
        end else if (i_sample_in_strobe && (r_timer != '1)) begin
            w_timer_d = r_timer + TIMER_WIDTH'(1);
        end else begin
            w_timer_d = r_timer;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_timer        <= '0;
            r_byte_cnt     <= '0;
            r_pkt_len      <= '0;
            r_pulse_cnt    <= '0;
            r_core_rst     <= 1'b0;
            r_abort_strobe <= 1'b0;
            r_abort_code   <= 3'd0;
            r_abort_count  <= '0;
            r_pkt_done     <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_timer        <= w_timer_d;
            r_byte_cnt     <= w_byte_cnt_d;
            r_pkt_len      <= w_pkt_len_d;
            r_pulse_cnt    <= w_pulse_cnt_d;
            r_core_rst     <= (w_state_d == StResetCore);
            r_abort_strobe <= w_abort;
            r_pkt_done     <= w_done_d;
            if (w_abort) begin
                r_abort_code <= w_code;
                if (r_abort_count != '1) r_abort_count <= r_abort_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_core_rst        = r_core_rst;
    assign o_abort_strobe    = r_abort_strobe;
    assign o_abort_code      = r_abort_code;
    assign o_abort_count     = r_abort_count;
    assign o_pkt_done_strobe = r_pkt_done;
    assign o_state           = r_state;

endmodule

// File: tb/tb_openofdm_rx_watchdog.sv
// Randomized scenario bench for openofdm_rx_watchdog; expectations come from the phase rules
// (sample counts versus timeouts, header/length rules, saturating abort tally).
module tb_openofdm_rx_watchdog;

    localparam int TW        = 16;
    localparam int PULSE     = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, en, sample, short_p, long_p, hdr_stb, hdr_valid, ht;
    logic [15:0]      pkt_len, max_len;
    logic             byte_stb, fcs_stb;
    logic [TW-1:0]    long_to, sig_to, byte_to;
    logic             core_rst, abort_stb, done;
    logic [2:0]       abort_code, state;
    logic [CNT_W-1:0] abort_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count = 0;
    int n_rst_hi = 0;
    int n_abort_seen = 0;

    always #5 clk = ~clk;

    openofdm_rx_watchdog #(
        .TIMER_WIDTH  (TW),
        .RST_PULSE_LEN(PULSE),
        .CNT_WIDTH    (CNT_W)
    ) dut (
        .i_clock                  (clk),
        .i_reset                  (rst),
        .i_enable                 (en),
        .i_sample_in_strobe       (sample),
        .i_short_preamble_detected(short_p),
        .i_long_preamble_detected (long_p),
        .i_pkt_header_valid_strobe(hdr_stb),
        .i_pkt_header_valid       (hdr_valid),
        .i_ht_unsupport           (ht),
        .i_pkt_len                (pkt_len),
        .i_byte_out_strobe        (byte_stb),
        .i_fcs_out_strobe         (fcs_stb),
        .i_long_timeout           (long_to),
        .i_sig_timeout            (sig_to),
        .i_byte_timeout           (byte_to),
        .i_max_pkt_len            (max_len),
        .o_core_rst               (core_rst),
        .o_abort_strobe           (abort_stb),
        .o_abort_code             (abort_code),
        .o_abort_count            (abort_count),
        .o_pkt_done_strobe        (done),
        .o_state                  (state)
    );

    always @(negedge clk) begin
        if (core_rst === 1'b1)  n_rst_hi++;
        if (abort_stb === 1'b1) n_abort_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_short();
        short_p = 1'b1; tick(); short_p = 1'b0;
    endtask

    task automatic drv_long();
        long_p = 1'b1; tick(); long_p = 1'b0;
    endtask

    task automatic drv_header(input bit v, input bit h, input int len);
        hdr_stb = 1'b1; hdr_valid = v; ht = h; pkt_len = 16'(len);
        tick();
        hdr_stb = 1'b0; hdr_valid = 1'b0; ht = 1'b0;
    endtask

    task automatic drv_byte();
        byte_stb = 1'b1; tick(); byte_stb = 1'b0;
    endtask

    task automatic enter_rx(input int len);
        drv_short(); drv_long(); drv_header(1'b1, 1'b0, len);
    endtask

    // Feeds random sample strobes until `to` samples have been seen; leaves the bench in the
    // cycle whose timer value equals `to`. bad is set if the FSM leaves state st early.
    task automatic feed(input int to, input int st, output bit bad);
        int n = 0;
        int guard = 0;
        bad = 1'b0;
        while (n < to && guard < 10000) begin
            if (state !== 3'(st)) bad = 1'b1;
            sample = 1'($urandom_range(0, 1));
            if (sample) n++;
            guard++;
            tick();
        end
        sample = 1'b0;
        if (state !== 3'(st) || n < to) bad = 1'b1;
    endtask

    // Counts core_rst/abort_strobe cycles from the current RESET_CORE cycle until IDLE.
    task automatic watch_pulse(output int rst_hi, output int stb_hi, output int cyc);
        rst_hi = 0; stb_hi = 0; cyc = 0;
        while (state !== 3'd0 && cyc < 20) begin
            if (core_rst === 1'b1)  rst_hi++;
            if (abort_stb === 1'b1) stb_hi++;
            cyc++;
            tick();
        end
    endtask

    function automatic int hdr_code(input bit v, input bit h, input int len, input int mx);
        if (!v || h) return 3;
        if (len == 0 || len > mx) return 5;
        return 0;
    endfunction

    // Drives scenario `kind` up to its abort decision and one cycle beyond.
    task automatic provoke(input int kind, output int exp_code, output bit early);
        int to, len, mx;
        bit v, h, bad;
        early = 1'b0;
        long_to = '0; sig_to = '0; byte_to = '0; max_len = 16'd4095;
        case (kind)
            0, 1: begin
                to = (kind == 0) ? 50 : int'($urandom_range(1, 120));
                long_to = TW'(to);
                drv_short();
                feed(to, 1, bad); early |= bad;
                tick();
                exp_code = 1;
            end
            2: begin
                to = $urandom_range(1, 120);
                sig_to = TW'(to);
                drv_short(); drv_long();
                feed(to, 2, bad); early |= bad;
                tick();
                exp_code = 2;
            end
            8: begin
                byte_to = TW'(200);
                enter_rx(10);
                for (int i = 0; i < 3; i++) begin
                    drv_byte();
                    if (state !== 3'd3) early = 1'b1;
                end
                feed(200, 3, bad); early |= bad;
                tick();
                exp_code = 4;
            end
            9: begin
                len = $urandom_range(1, 20);
                enter_rx(len);
                for (int i = 0; i < len; i++) begin
                    if (state !== 3'd3) early = 1'b1;
                    drv_byte();
                end
                if (state !== 3'd3) early = 1'b1;
                drv_byte();
                exp_code = 6;
            end
            default: begin
                v = 1'b1; h = 1'b0; len = 100;
                if (kind == 3) begin
                    v = 1'b0; h = 1'($urandom_range(0, 1)); len = $urandom_range(1, 4095);
                end else if (kind == 4) begin
                    h = 1'b1;
                end else if (kind == 5) begin
                    len = 5000;
                end else if (kind == 6) begin
                    len = 0;
                end else begin
                    mx = $urandom_range(1, 60000);
                    max_len = 16'(mx);
                    len = $urandom_range(mx + 1, 65535);
                end
                drv_short(); drv_long();
                if (state !== 3'd2) early = 1'b1;
                drv_header(v, h, len);
                exp_code = hdr_code(v, h, len, int'(max_len));
            end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        n_checks++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (core_rst !== 1'b0) $display("FAIL reset_core_rst: got %b want 0", core_rst); else n_pass++;
        n_checks++; if (abort_stb !== 1'b0) $display("FAIL reset_abort_strobe: got %b want 0", abort_stb); else n_pass++;
        n_checks++; if (abort_code !== 3'd0) $display("FAIL reset_abort_code: got %0d want 0", abort_code); else n_pass++;
        n_checks++; if (abort_count !== '0) $display("FAIL reset_abort_count: got %0d want 0", abort_count); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_pkt_done: got %b want 0", done); else n_pass++;
        rst = 1'b0; tick();
        exp_count = 0;
    endtask

    task automatic test_good_packet();
        int rst_before, gap;
        long_to = '0; sig_to = '0; byte_to = TW'(1000); max_len = 16'd4095;
        rst_before = n_rst_hi;
        enter_rx(100);
        n_checks++; if (state !== 3'd3) $display("FAIL good_rx_state: got %0d want 3", state); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                sample = 1'b1; tick();
            end
            sample = 1'($urandom_range(0, 1));
            drv_byte();
            sample = 1'b0;
        end
        n_checks++; if (state !== 3'd3) $display("FAIL good_after_bytes: got %0d want 3", state); else n_pass++;
        fcs_stb = 1'b1; tick(); fcs_stb = 1'b0;
        n_checks++; if (done !== 1'b1) $display("FAIL good_done: got %b want 1", done); else n_pass++;
        n_checks++; if (state !== 3'd0) $display("FAIL good_idle: got %0d want 0", state); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL good_done_width: got %b want 0", done); else n_pass++;
        n_checks++; if (int'(abort_count) !== exp_count) $display("FAIL good_count: got %0d want %0d", abort_count, exp_count); else n_pass++;
        n_checks++; if (n_rst_hi !== rst_before) $display("FAIL good_core_rst: got %0d want %0d", n_rst_hi, rst_before); else n_pass++;
    endtask

    task automatic test_aborts();
        int code, rh, sh, cyc;
        bit early;
        for (int k = 0; k < 10; k++) begin
            provoke(k, code, early);
            if (exp_count < CNT_MAX) exp_count++;
            n_checks++; if (early !== 1'b0) $display("FAIL abort_early k%0d: got %b want 0", k, early); else n_pass++;
            n_checks++; if (state !== 3'd4) $display("FAIL abort_state k%0d: got %0d want 4", k, state); else n_pass++;
            n_checks++; if (abort_stb !== 1'b1) $display("FAIL abort_strobe k%0d: got %b want 1", k, abort_stb); else n_pass++;
            n_checks++; if (core_rst !== 1'b1) $display("FAIL abort_core_rst k%0d: got %b want 1", k, core_rst); else n_pass++;
            n_checks++; if (int'(abort_code) !== code) $display("FAIL abort_code k%0d: got %0d want %0d", k, abort_code, code); else n_pass++;
            n_checks++; if (int'(abort_count) !== exp_count) $display("FAIL abort_count k%0d: got %0d want %0d", k, abort_count, exp_count); else n_pass++;
            watch_pulse(rh, sh, cyc);
            n_checks++; if (rh !== PULSE) $display("FAIL abort_rst_len k%0d: got %0d want %0d", k, rh, PULSE); else n_pass++;
            n_checks++; if (sh !== 1) $display("FAIL abort_strobe_len k%0d: got %0d want 1", k, sh); else n_pass++;
            n_checks++; if (cyc !== PULSE) $display("FAIL abort_to_idle k%0d: got %0d want %0d", k, cyc, PULSE); else n_pass++;
            n_checks++; if (core_rst !== 1'b0) $display("FAIL abort_rst_drop k%0d: got %b want 0", k, core_rst); else n_pass++;
        end
    endtask

    task automatic test_fcs_precedence();
        int t, seen;
        bit bad;
        long_to = '0; sig_to = '0; max_len = 16'd4095;
        t = $urandom_range(5, 50);
        byte_to = TW'(t);
        enter_rx(5);
        drv_byte(); drv_byte();
        seen = n_abort_seen;
        feed(t, 3, bad);
        fcs_stb = 1'b1; tick(); fcs_stb = 1'b0;
        n_checks++; if (bad !== 1'b0) $display("FAIL fcs_prec_early: got %b want 0", bad); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL fcs_prec_done: got %b want 1", done); else n_pass++;
        n_checks++; if (state !== 3'd0) $display("FAIL fcs_prec_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (n_abort_seen !== seen) $display("FAIL fcs_prec_abort: got %0d want %0d", n_abort_seen, seen); else n_pass++;
    endtask

    task automatic test_long_precedence();
        int t;
        bit bad;
        sig_to = '0; byte_to = '0;
        t = $urandom_range(3, 40);
        long_to = TW'(t);
        drv_short();
        feed(t, 1, bad);
        long_p = 1'b1; tick(); long_p = 1'b0;
        n_checks++; if (bad !== 1'b0) $display("FAIL long_prec_early: got %b want 0", bad); else n_pass++;
        n_checks++; if (state !== 3'd2) $display("FAIL long_prec_state: got %0d want 2", state); else n_pass++;
        n_checks++; if (abort_stb !== 1'b0) $display("FAIL long_prec_abort: got %b want 0", abort_stb); else n_pass++;
        en = 1'b0; tick(); en = 1'b1;
        n_checks++; if (state !== 3'd0) $display("FAIL long_prec_disable: got %0d want 0", state); else n_pass++;
    endtask

    task automatic test_enable_drop();
        long_to = '0; sig_to = '0; byte_to = '0; max_len = 16'd4095;
        drv_short(); drv_long(); drv_header(1'b0, 1'b0, 50);
        if (exp_count < CNT_MAX) exp_count++;
        drv_short();
        n_checks++; if (state !== 3'd4) $display("FAIL en_short_ignored: got %0d want 4", state); else n_pass++;
        n_checks++; if (core_rst !== 1'b1) $display("FAIL en_pulse_on: got %b want 1", core_rst); else n_pass++;
        en = 1'b0; tick();
        n_checks++; if (state !== 3'd0) $display("FAIL en_drop_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (core_rst !== 1'b0) $display("FAIL en_drop_rst: got %b want 0", core_rst); else n_pass++;
        n_checks++; if (abort_code !== 3'd3) $display("FAIL en_code_held: got %0d want 3", abort_code); else n_pass++;
        n_checks++; if (int'(abort_count) !== exp_count) $display("FAIL en_count_held: got %0d want %0d", abort_count, exp_count); else n_pass++;
        drv_short();
        n_checks++; if (state !== 3'd0) $display("FAIL en_off_ignores: got %0d want 0", state); else n_pass++;
        en = 1'b1; tick();
    endtask

    task automatic test_saturation();
        int guard;
        long_to = '0; sig_to = '0; byte_to = '0; max_len = 16'd4095;
        for (int k = 0; k < 8; k++) begin
            drv_short(); drv_long(); drv_header(1'b0, 1'b1, 10);
            if (exp_count < CNT_MAX) exp_count++;
            n_checks++; if (int'(abort_count) !== exp_count) $display("FAIL sat_count n%0d: got %0d want %0d", k, abort_count, exp_count); else n_pass++;
            guard = 0;
            while (state !== 3'd0 && guard < 20) begin
                tick(); guard++;
            end
        end
        n_checks++; if (int'(abort_count) !== CNT_MAX) $display("FAIL sat_final: got %0d want %0d", abort_count, CNT_MAX); else n_pass++;
    endtask

    task automatic test_reset_midop();
        long_to = '0; sig_to = '0; byte_to = '0;
        drv_short(); drv_long();
        n_checks++; if (state !== 3'd2) $display("FAIL rst_mid_pre: got %0d want 2", state); else n_pass++;
        rst = 1'b1; tick();
        exp_count = 0;
        n_checks++; if (state !== 3'd0) $display("FAIL rst_mid_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (abort_count !== '0) $display("FAIL rst_mid_count: got %0d want 0", abort_count); else n_pass++;
        n_checks++; if (abort_code !== 3'd0) $display("FAIL rst_mid_code: got %0d want 0", abort_code); else n_pass++;
        rst = 1'b0; tick();
        drv_short(); drv_long(); drv_header(1'b0, 1'b0, 10);
        n_checks++; if (core_rst !== 1'b1) $display("FAIL rst_pulse_pre: got %b want 1", core_rst); else n_pass++;
        rst = 1'b1; tick();
        n_checks++; if (core_rst !== 1'b0) $display("FAIL rst_pulse_drop: got %b want 0", core_rst); else n_pass++;
        n_checks++; if (abort_stb !== 1'b0) $display("FAIL rst_pulse_strobe: got %b want 0", abort_stb); else n_pass++;
        n_checks++; if (state !== 3'd0) $display("FAIL rst_pulse_state: got %0d want 0", state); else n_pass++;
        rst = 1'b0; tick();
    endtask

    task automatic test_zero_timeouts();
        int seen;
        long_to = '0; sig_to = '0; byte_to = '0;
        seen = n_abort_seen;
        drv_short();
        sample = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        sample = 1'b0;
        tick();
        n_checks++; if (state !== 3'd1) $display("FAIL zero_to_state: got %0d want 1", state); else n_pass++;
        n_checks++; if (n_abort_seen !== seen) $display("FAIL zero_to_abort: got %0d want %0d", n_abort_seen, seen); else n_pass++;
        en = 1'b0; tick(); en = 1'b1; tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sample = 1'b0; short_p = 1'b0; long_p = 1'b0;
        hdr_stb = 1'b0; hdr_valid = 1'b0; ht = 1'b0; pkt_len = '0;
        byte_stb = 1'b0; fcs_stb = 1'b0;
        long_to = '0; sig_to = '0; byte_to = '0; max_len = 16'd4095;
        test_reset();
        test_good_packet();
        test_aborts();
        test_fcs_precedence();
        test_long_precedence();
        test_enable_drop();
        test_saturation();
        test_reset_midop();
        test_zero_timeouts();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/openofdm_rx_watchdog.md
Name: openofdm_rx_watchdog

Overview:
- Supervisory sequencer beside the dot11 receive core.
- Tracks each reception through short preamble, long preamble, SIGNAL header, data bytes and FCS, using the core's status strobes.
- Stalls, bad headers and byte overruns are recovery events. On one, it pulses a core reset for a fixed count and records why. The reset is ORed into the dot11 reset.
- Timeouts come from AXI config registers. abort_code and abort_count are readable as status.

Parameters:
- TIMER_WIDTH, 16: width of the sample-strobe timers and timeout inputs.
- RST_PULSE_LEN, 4: clock cycles core_rst stays high per abort (>=1).
- CNT_WIDTH, 16: width of abort_count.

Ports:
- clock  in  1  system clock (AXI clock domain).
- reset  in  1  synchronous, active-high.
- enable  in  1  0 forces IDLE; no aborts are generated.
- sample_in_strobe  in  1  timer tick; one per input IQ sample.
- short_preamble_detected  in  1  pulse from core.
- long_preamble_detected  in  1  pulse from core.
- pkt_header_valid_strobe  in  1  header decision pulse.
- pkt_header_valid  in  1  qualifies the header strobe.
- ht_unsupport  in  1  qualifies the header strobe.
- pkt_len  in  16  byte length, sampled on the header strobe.
- byte_out_strobe  in  1  one decoded byte.
- fcs_out_strobe  in  1  end of packet.
- long_timeout  in  TIMER_WIDTH  samples allowed from short to long preamble; 0 disables the check.
- sig_timeout  in  TIMER_WIDTH  samples allowed from long preamble to header; 0 disables the check.
- byte_timeout  in  TIMER_WIDTH  samples allowed between bytes in RX_DATA; 0 disables the check.
- max_pkt_len  in  16  largest acceptable pkt_len.
- core_rst  out  1  reset request to the core.
- abort_strobe  out  1  one-cycle pulse per abort.
- abort_code  out  3  cause of the last abort; held until the next abort.
- abort_count  out  CNT_WIDTH  saturating count of aborts.
- pkt_done_strobe  out  1  one-cycle pulse on normal completion.
- state  out  3  current FSM state.

Behaviour:
- Reset values: core_rst=0, abort_strobe=0, abort_code=0, abort_count=0, pkt_done_strobe=0, state=IDLE. Internal timer and byte counter are cleared.
- States: IDLE=0, WAIT_LONG=1, WAIT_SIG=2, RX_DATA=3, RESET_CORE=4.
- Timer:
  - Cleared on every state entry and on every byte_out_strobe in RX_DATA.
  - Increments by 1 per sample_in_strobe and saturates at all-ones.
  - A timeout fires when timer >= the active timeout and that timeout is nonzero.
- IDLE:
  - short_preamble_detected -> WAIT_LONG.
  - All other inputs are ignored.
- WAIT_LONG:
  - long_preamble_detected -> WAIT_SIG.
  - Else on timeout(long_timeout) -> abort, code 1.
- WAIT_SIG, on pkt_header_valid_strobe:
  - If pkt_header_valid=1, ht_unsupport=0, pkt_len!=0 and pkt_len<=max_pkt_len -> RX_DATA; pkt_len is latched.
  - If pkt_header_valid=0 or ht_unsupport=1 -> abort, code 3.
  - If the header is valid but the length check fails -> abort, code 5.
  - With no strobe, timeout(sig_timeout) -> abort, code 2.
- RX_DATA:
  - byte_out_strobe increments the byte counter.
  - fcs_out_strobe -> IDLE and pkt_done_strobe=1 on the next cycle.
  - Else if the byte counter would exceed the latched length -> abort, code 6.
  - Else timeout(byte_timeout) -> abort, code 4.
- Precedence within one cycle: state-advancing strobe > abort check. Consequences:
  - fcs_out_strobe together with a timeout gives normal completion.
  - long_preamble together with a long timeout advances.
- Abort timing, decision registered at cycle t:
  - Cycle t+1: state=RESET_CORE, core_rst=1, abort_strobe=1 (one cycle only), abort_code updated, abort_count+1 (saturating).
  - core_rst stays high for exactly RST_PULSE_LEN cycles.
  - state=IDLE on cycle t+RST_PULSE_LEN+1.
- RESET_CORE ignores every input, including short_preamble_detected.
- short_preamble_detected outside IDLE is ignored.
- enable=0:
  - Next cycle state=IDLE and core_rst=0, which truncates any pulse in progress.
  - Timer and byte counter are cleared; abort_code and abort_count are held.
- Reset mid-operation: all registers go to their reset values on the next edge, including mid-pulse (core_rst drops).
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Good packet:
  - Stimulus: short, long, header with valid=1, pkt_len=100; then 100 byte strobes and fcs_out_strobe.
  - Response: pkt_done_strobe for 1 cycle, state returns to 0, abort_count=0, core_rst never high.
- Long timeout:
  - Stimulus: long_timeout=50; short preamble, then 50 sample strobes with no long preamble.
  - Response: abort_strobe, abort_code=1, core_rst high exactly 4 cycles, then IDLE, abort_count=1.
- Bad header:
  - Case A, pkt_header_valid=0 on the strobe: abort_code=3.
  - Case B, valid header with pkt_len=5000 and max_pkt_len=4095: abort_code=5.
  - Case C, pkt_len=0: abort_code=5.
- Data stall and overrun:
  - Stall: byte_timeout=200, pkt_len=10, only 3 bytes followed by 200 sample strobes -> code 4.
  - Overrun: 11 bytes with no FCS -> code 6 on the 11th byte.
- Precedence and disable:
  - fcs_out_strobe in the same cycle as the byte timeout reaching its limit -> pkt_done_strobe, no abort.
  - enable dropped during RESET_CORE -> core_rst low next cycle, state=0.
- Saturation and reset:
  - Force abort_count to all-ones -> it stays all-ones.
  - Assert reset during WAIT_SIG -> all outputs at reset values next cycle.
  - Timeouts of 0 -> no abort after 65535+ samples.
